uart_rx: RTL
============

# uart_rx

UART receiver that deserialises 8N1 frames from the serial line into bytes for the matrix engine's input loader. It is the receive-side counterpart of `uart_tx`, using the same frame format and bit timing, so `uart_tx.tx` can be looped back into `rx` for self-test. The block provides mid-bit sampling, a false-start glitch filter, and framing and overrun error reporting.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per bit (50 MHz / 115200). Legal range is 4 or more.
- `clk`  input  1  system clock, 50 MHz nominal.
- `reset`  input  1  asynchronous, active-high reset.
- `rx`  input  1  serial line, idle high, asynchronous to `clk`.
- `data_out`  output  8  last correctly received byte.
- `rx_valid`  output  1  one-cycle pulse when `data_out` is updated.
- `rx_ack`  input  1  consumer has taken `data_out`; clears the pending flag.
- `rx_busy`  output  1  high while a frame is in progress (any state other than IDLE).
- `frame_err`  output  1  one-cycle pulse when the stop bit is sampled low.
- `overrun`  output  1  sticky; set when a new byte arrives while the previous byte is still pending; cleared by `reset` only.

## Operation
- **Input synchroniser:** `rx` passes through a 2-flop synchroniser (`rx_s`).
  - Both flops reset to 1.
  - All decisions use `rx_s`.
- **States:** IDLE, START, DATA, STOP, BREAK.
  - A bit counter `cnt` (width clog2(CLKS_PER_BIT)) and a bit index `idx` (3 bits) control the sequencing.
- **IDLE:** when `rx_s`=0, go to START with `cnt`=0.
- **START:** increment `cnt` up to `HALF`=(CLKS_PER_BIT-1)/2.
  - At `cnt`==HALF, if `rx_s`=1 (glitch), return to IDLE with no output.
  - Otherwise clear `cnt`, set `idx`=0 and go to DATA.
- **DATA:** count to CLKS_PER_BIT-1.
  - At terminal count, shift `rx_s` into `shreg` LSB-first (into bit 7, shift right) and clear `cnt`.
  - After `idx`==7 is sampled, go to STOP. Otherwise increment `idx`.
- **STOP:** count to CLKS_PER_BIT-1, then sample `rx_s`.
  - If 1: next cycle `data_out`<=`shreg` and `rx_valid`=1 for one cycle. If `pending` is already set, also set `overrun`. Set `pending`. Go to IDLE.
  - If 0: `frame_err`=1 for one cycle, `data_out` unchanged, go to BREAK.
- **BREAK:** wait for `rx_s`=1, then go to IDLE. This prevents a held-low line from being read as repeated frames.
- **Pending flag:** `rx_ack` clears `pending`. If `rx_ack` and a new `rx_valid` occur in the same cycle, the new byte wins: `pending` stays 1 and no overrun is flagged.
- **Back-to-back frames:** the return to IDLE at mid-stop-bit lets a start bit that immediately follows be accepted with no lost bit.

## Timing
- **Reset values:**
  - `data_out`=8'h00, `rx_valid`=0, `frame_err`=0, `overrun`=0, `rx_busy`=0.
  - Internally: `pending`=0 and state=IDLE.
- **Reset mid-frame:** asynchronous reset aborts immediately. No `rx_valid` or `frame_err` is produced for the aborted frame.
- **Synchroniser latency:** 2 cycles from an `rx` edge to `rx_s`.
- **Start-bit sample:** taken HALF+1 cycles after IDLE sees `rx_s`=0.
- **Data-bit samples:** at multiples of CLKS_PER_BIT after the start sample.
- **Latency:** `rx_valid` asserts 1 cycle after the stop-bit sample. That is about 2 + HALF + 9·CLKS_PER_BIT + 2 cycles after the falling edge of `rx`.
- **Glitch rejection:** a low pulse shorter than HALF cycles is rejected.
- **Clock tolerance:** ±2% baud mismatch between transmitter and receiver is tolerated.
- `rx_busy` is combinational from state: high in START, DATA, STOP and BREAK.

## Test plan
- **Single byte:** CLKS_PER_BIT=16. Drive frame 0x55 via a `uart_tx` loopback → one `rx_valid` pulse, `data_out`=0x55, `frame_err`=0, `rx_busy` low afterwards.
- **Back-to-back frames:** send 0xA5 then 0x3C with no idle gap, asserting `rx_ack` after each → two `rx_valid` pulses, `data_out`=0xA5 then 0x3C, `overrun`=0.
- **False start:** drive `rx` low for 5 cycles (CLKS_PER_BIT=16), then high → no `rx_valid`, state returns to IDLE, `rx_busy` low within 12 cycles.
- **Framing error:** send 0xF0 with stop bit forced 0, then hold low for 40 cycles, then high → `frame_err` pulses once, `data_out` keeps its prior value, no new frame until the line goes high. A following 0x81 is received correctly.
- **Overrun:** send 0x11 and 0x22 without `rx_ack` → `overrun`=1 sticky, `data_out`=0x22. Then `rx_ack` plus a third byte 0x33 → `overrun` still 1, `data_out`=0x33.
- **Reset mid-frame:** assert `reset` after 4 data bits → all outputs return to their reset values, no `rx_valid` is produced. A clean 0xC3 frame sent after reset release is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling, glitch filter, framing and overrun flags
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rx_ack,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);

    // Counter wide enough to reach CLKS_PER_BIT-1.
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic          r_rx_meta;
    logic          r_rx_s;
    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shreg;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_ferr;
    logic          r_overrun;
    logic          r_pending;

    logic [2:0]    w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    w_idx_nxt;
    logic [7:0]    w_shreg_nxt;
    logic          w_cnt_half;
    logic          w_cnt_last;
    logic          w_stop_ok;
    logic          w_stop_bad;

    assign w_cnt_half = (r_cnt == HALF);
    assign w_cnt_last = (r_cnt == LAST);
    assign w_stop_ok  = (r_state == S_STOP) && w_cnt_last && r_rx_s;
    assign w_stop_bad = (r_state == S_STOP) && w_cnt_last && !r_rx_s;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Frame sequencing: next state, bit-timing counter, bit index and shift register.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shreg_nxt = r_shreg;
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = '0;
                end
            end
            S_START: begin
                if (w_cnt_half) begin
                    if (r_rx_s) begin
                        // Line went back high before mid-start: treat as a glitch.
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_DATA;
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = 3'd0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (w_cnt_last) begin
                    w_shreg_nxt = {r_rx_s, r_shreg[7:1]};
                    w_cnt_nxt   = '0;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_STOP: begin
                if (w_cnt_last) begin
                    w_cnt_nxt = '0;
                    // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start.
                    w_state_nxt = r_rx_s ? S_IDLE : S_BREAK;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_BREAK: begin
                // A held-low line must return high before another frame is accepted.
                if (r_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Sequencing registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_shreg <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shreg <= w_shreg_nxt;
        end
    end

    // Byte delivery and single-cycle status pulses, registered off the stop sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_valid <= w_stop_ok;
            r_ferr  <= w_stop_bad;
            if (w_stop_ok) begin
                r_data <= r_shreg;
            end
        end
    end

    // Pending/overrun tracking; a new byte beats a simultaneous acknowledge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_stop_ok) begin
                r_pending <= 1'b1;
                if (r_pending && !rx_ack) begin
                    r_overrun <= 1'b1;
                end
            end else if (rx_ack) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign data_out  = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_ferr;
    assign overrun   = r_overrun;
    assign rx_busy   = (r_state != S_IDLE);

endmodule
